// File: rtl/fifo_sc_parity.sv
// fifo_sc_parity: single-clock FIFO with one parity bit per word, occupancy flags and sticky error flags
module fifo_sc_parity #(
    parameter int lpm_width   = 4,
    parameter int lpm_widthad = 4,
    parameter bit parity_odd  = 1'b0,
    parameter int af_level    = 14,
    parameter int ae_level    = 2
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [lpm_width-1:0]   Data,
    input  logic                   WrEn,
    input  logic                   EDI,
    input  logic                   RdEn,
    output logic [lpm_width-1:0]   Q,
    output logic                   ParityErr,
    output logic                   ParityErrSticky,
    output logic                   Full,
    output logic                   Empty,
    output logic                   AlmostFull,
    output logic                   AlmostEmpty,
    output logic                   Overflow,
    output logic                   Underflow,
    output logic [lpm_widthad:0]   Count
);
    localparam int depth = 2 ** lpm_widthad;
    localparam logic [lpm_widthad:0]   depth_c = (lpm_widthad + 1)'(depth);
    localparam logic [lpm_widthad:0]   af_c    = (lpm_widthad + 1)'(af_level);
    localparam logic [lpm_widthad:0]   ae_c    = (lpm_widthad + 1)'(ae_level);
    localparam logic [lpm_widthad:0]   cnt_one = (lpm_widthad + 1)'(1);
    localparam logic [lpm_widthad-1:0] ptr_one = (lpm_widthad)'(1);

    logic [lpm_width:0]     mem_q [depth];
    logic [lpm_width:0]     rd_word, wr_word;
    logic [lpm_widthad-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [lpm_widthad:0]   count_q, count_d;
    logic [lpm_width-1:0]   q_q, q_d;
    logic perr_q, perr_d, sticky_q, sticky_d;
    logic full_q, full_d, empty_q, empty_d, afull_q, afull_d, aempty_q, aempty_d;
    logic ovf_q, ovf_d, udf_q, udf_d;
    logic rd_acc, wr_acc;

    // accept logic, next pointers, occupancy and flags computed from post-edge occupancy
    always_comb begin
        rd_acc   = RdEn & ~empty_q;
        wr_acc   = WrEn & (~full_q | rd_acc);
        rd_word  = mem_q[rd_ptr_q];
        wr_word  = {(^Data) ^ parity_odd ^ EDI, Data};
        wr_ptr_d = wr_acc ? wr_ptr_q + ptr_one : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ptr_one : rd_ptr_q;
        count_d  = (wr_acc & ~rd_acc) ? count_q + cnt_one :
                   (rd_acc & ~wr_acc) ? count_q - cnt_one : count_q;
        full_d   = count_d == depth_c;
        empty_d  = count_d == '0;
        afull_d  = count_d >= af_c;
        aempty_d = count_d <= ae_c;
        q_d      = rd_acc ? rd_word[lpm_width-1:0] : q_q;
        perr_d   = rd_acc ? (^rd_word) ^ parity_odd : perr_q;
        sticky_d = sticky_q | perr_d;
        ovf_d    = ovf_q | (WrEn & full_q & ~rd_acc);
        udf_d    = udf_q | (RdEn & empty_q);
    end

    // word array with parity bit; contents survive reset, a full-FIFO read sees the old word
    always_ff @(posedge Clock) begin
        if (wr_acc & ~Reset) mem_q[wr_ptr_q] <= wr_word;
    end

    // pointers, occupancy, read data and flags
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            q_q      <= '0;
            perr_q   <= 1'b0;
            sticky_q <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= af_c == '0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            q_q      <= q_d;
            perr_q   <= perr_d;
            sticky_q <= sticky_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign Q               = q_q;
    assign ParityErr       = perr_q;
    assign ParityErrSticky = sticky_q;
    assign Full            = full_q;
    assign Empty           = empty_q;
    assign AlmostFull      = afull_q;
    assign AlmostEmpty     = aempty_q;
    assign Overflow        = ovf_q;
    assign Underflow       = udf_q;
    assign Count           = count_q;
endmodule

// File: tb/tb_fifo_sc_parity.sv
// tb_fifo_sc_parity: scoreboard bench driving an even- and an odd-parity FIFO against a queue model
module tb_fifo_sc_parity;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, wr = 1'b0, rd = 1'b0, edi = 1'b0;
    logic [3:0] data = '0;
    logic [3:0] q [2];
    logic [4:0] cnt [2];
    logic perr [2], stk [2], full [2], empty [2], af [2], ae [2], ovf [2], udf [2];

    fifo_sc_parity #(.parity_odd(1'b0)) dut_e (
        .Clock(clk), .Reset(rst), .Data(data), .WrEn(wr), .EDI(edi), .RdEn(rd),
        .Q(q[0]), .ParityErr(perr[0]), .ParityErrSticky(stk[0]), .Full(full[0]),
        .Empty(empty[0]), .AlmostFull(af[0]), .AlmostEmpty(ae[0]), .Overflow(ovf[0]),
        .Underflow(udf[0]), .Count(cnt[0])
    );

    fifo_sc_parity #(.parity_odd(1'b1)) dut_o (
        .Clock(clk), .Reset(rst), .Data(data), .WrEn(wr), .EDI(edi), .RdEn(rd),
        .Q(q[1]), .ParityErr(perr[1]), .ParityErrSticky(stk[1]), .Full(full[1]),
        .Empty(empty[1]), .AlmostFull(af[1]), .AlmostEmpty(ae[1]), .Overflow(ovf[1]),
        .Underflow(udf[1]), .Count(cnt[1])
    );

    typedef struct packed {
        logic [3:0] q;
        logic perr, stk, full, empty, af, ae, ovf, udf;
        logic [4:0] cnt;
    } exp_t;

    exp_t exp_q [$];
    logic [4:0] mdl [$];
    exp_t m = '0;
    int errors = 0, checks = 0;

    task automatic chk(input string n, input int k, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d", n, k, a, e);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rr, input logic e, input logic [3:0] d);
        logic rok, wok;
        logic [4:0] x;
        @(negedge clk);
        rst = r; wr = w; rd = rr; edi = e; data = d;
        if (r) begin
            mdl.delete();
            m = '0;
        end else begin
            rok = rr && mdl.size() > 0;
            wok = w && (mdl.size() < 16 || rok);
            if (rr && mdl.size() == 0) m.udf = 1'b1;
            if (w && mdl.size() == 16 && !rok) m.ovf = 1'b1;
            if (rok) begin
                x = mdl.pop_front();
                m.q = x[3:0];
                m.perr = x[4];
                m.stk = m.stk | x[4];
            end
            if (wok) mdl.push_back({e, d});
        end
        m.cnt   = 5'(mdl.size());
        m.full  = mdl.size() == 16;
        m.empty = mdl.size() == 0;
        m.af    = mdl.size() >= 14;
        m.ae    = mdl.size() <= 2;
        exp_q.push_back(m);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int k = 0; k < 2; k++) begin
                chk("Count", k, 32'(cnt[k]), 32'(e.cnt));
                chk("Q", k, 32'(q[k]), 32'(e.q));
                chk("ParityErr", k, 32'(perr[k]), 32'(e.perr));
                chk("ParityErrSticky", k, 32'(stk[k]), 32'(e.stk));
                chk("Full", k, 32'(full[k]), 32'(e.full));
                chk("Empty", k, 32'(empty[k]), 32'(e.empty));
                chk("AlmostFull", k, 32'(af[k]), 32'(e.af));
                chk("AlmostEmpty", k, 32'(ae[k]), 32'(e.ae));
                chk("Overflow", k, 32'(ovf[k]), 32'(e.ovf));
                chk("Underflow", k, 32'(udf[k]), 32'(e.udf));
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 4'(i));
        step(0, 1, 0, 0, 4'hA);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 4'h5);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 4'h3);
        step(0, 1, 0, 0, 4'h6);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 4'($urandom));
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) step(0, i < 12, i >= 4, 0, 4'($urandom));
        for (int p = 0; p < 6; p++)
            for (int i = 0; i < 60; i++)
                step($urandom_range(0, 79) == 0,
                     $urandom_range(0, 3) < ((p % 2) ? 3 : 1),
                     $urandom_range(0, 3) < ((p % 2) ? 1 : 3),
                     $urandom_range(0, 7) == 0, 4'($urandom));
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, i == 2, 4'(i + 8));
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("drain", 0, 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
